special_item_placer: RTL and testbench

- Upstream feeder for the special-box draw stage. Picks pseudo-random free maze cells for the "plus" and "minus" power-up items and presents them as 5-bit grid coordinates.
- Drives the draw stage's drawSpecial request and waits for its done.
- Detects when the player occupies an item cell, pulses a pickup event, then respawns that item after a delay.
- Sits between the level controller / maze wall memory and the special-box renderer.

---
 rtl/special_item_placer.sv | 169 ++++++++++++++++
 tb/tb_special_item_placer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/special_item_placer.sv
// Places the "plus" and "minus" power-up items on free maze cells, hands them to the
// special-box draw stage, and respawns an item some time after the player picks it up.
module special_item_placer #(
   parameter int          GRID_W         = 24,
   parameter int          GRID_H         = 24,
   parameter logic [15:0] LFSR_SEED      = 16'hACE1,
   parameter int          RESPAWN_CYCLES = 50000000
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       start,
   input  logic [4:0] player_x,
   input  logic [4:0] player_y,
   output logic [9:0] maze_addr,
   input  logic       maze_wall,
   output logic [4:0] x_plus,
   output logic [4:0] y_plus,
   output logic [4:0] x_minus,
   output logic [4:0] y_minus,
   output logic       draw_special,
   input  logic       draw_done,
   output logic       plus_taken,
   output logic       minus_taken,
   output logic       busy
);

   localparam int CNT_W = $clog2(RESPAWN_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RESPAWN_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [5:0] GW   = 6'(GRID_W);
   localparam logic [5:0] GH   = 6'(GRID_H);
   localparam logic [9:0] GW10 = 10'(GRID_W);

   localparam logic [3:0] S_IDLE          = 4'd0;
   localparam logic [3:0] S_GEN_PLUS      = 4'd1;
   localparam logic [3:0] S_READ_PLUS     = 4'd2;
   localparam logic [3:0] S_CHECK_PLUS    = 4'd3;
   localparam logic [3:0] S_GEN_MINUS     = 4'd4;
   localparam logic [3:0] S_READ_MINUS    = 4'd5;
   localparam logic [3:0] S_CHECK_MINUS   = 4'd6;
   localparam logic [3:0] S_DRAW_SETUP    = 4'd7;
   localparam logic [3:0] S_DRAW          = 4'd8;
   localparam logic [3:0] S_ACTIVE        = 4'd9;
   localparam logic [3:0] S_RESPAWN_PLUS  = 4'd10;
   localparam logic [3:0] S_RESPAWN_MINUS = 4'd11;

   logic [3:0]       state_reg;
   logic [15:0]      lfsr_reg;
   logic [4:0]       cand_x_reg, cand_y_reg;
   logic             plus_valid_reg, minus_valid_reg;
   logic             both_reg;
   logic [CNT_W-1:0] cnt_reg;

   logic [4:0] gen_x, gen_y;
   logic       gen_ok;
   logic [9:0] gen_addr;
   logic       cand_on_player, reject_plus, reject_minus;
   logic       plus_hit, minus_hit;

   assign gen_x    = lfsr_reg[4:0];
   assign gen_y    = lfsr_reg[9:5];
   assign gen_ok   = ({1'b0, gen_x} < GW) && ({1'b0, gen_y} < GH);
   assign gen_addr = {5'b0, gen_y} * GW10 + {5'b0, gen_x};

   assign cand_on_player = (cand_x_reg == player_x) && (cand_y_reg == player_y);
   assign reject_plus  = maze_wall || cand_on_player ||
                         (minus_valid_reg && cand_x_reg == x_minus && cand_y_reg == y_minus);
   assign reject_minus = maze_wall || cand_on_player ||
                         (plus_valid_reg && cand_x_reg == x_plus && cand_y_reg == y_plus);

   assign plus_hit  = plus_valid_reg  && player_x == x_plus  && player_y == y_plus;
   assign minus_hit = minus_valid_reg && player_x == x_minus && player_y == y_minus;

   assign draw_special = (state_reg == S_DRAW);
   assign busy         = (state_reg != S_IDLE) && (state_reg != S_ACTIVE);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_reg       <= S_IDLE;
         lfsr_reg        <= LFSR_SEED;
         cand_x_reg      <= '0;
         cand_y_reg      <= '0;
         plus_valid_reg  <= 1'b0;
         minus_valid_reg <= 1'b0;
         both_reg        <= 1'b0;
         cnt_reg         <= '0;
         maze_addr       <= '0;
         x_plus          <= '0;
         y_plus          <= '0;
         x_minus         <= '0;
         y_minus         <= '0;
         plus_taken      <= 1'b0;
         minus_taken     <= 1'b0;
      end else begin
         lfsr_reg    <= {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
         plus_taken  <= 1'b0;
         minus_taken <= 1'b0;
         if (start) begin
            plus_valid_reg  <= 1'b0;
            minus_valid_reg <= 1'b0;
            cnt_reg         <= '0;
            both_reg        <= 1'b1;
            state_reg       <= S_GEN_PLUS;
         end else begin
            case (state_reg)
               S_GEN_PLUS, S_GEN_MINUS: begin
                  cand_x_reg <= gen_x;
                  cand_y_reg <= gen_y;
                  if (gen_ok) begin
                     maze_addr <= gen_addr;
                     state_reg <= (state_reg == S_GEN_PLUS) ? S_READ_PLUS : S_READ_MINUS;
                  end
               end
               S_READ_PLUS:  state_reg <= S_CHECK_PLUS;
               S_READ_MINUS: state_reg <= S_CHECK_MINUS;
               S_CHECK_PLUS: begin
                  if (reject_plus) begin
                     state_reg <= S_GEN_PLUS;
                  end else begin
                     x_plus         <= cand_x_reg;
                     y_plus         <= cand_y_reg;
                     plus_valid_reg <= 1'b1;
                     // a full level start places minus next; a respawn goes straight to redraw
                     state_reg      <= both_reg ? S_GEN_MINUS : S_DRAW_SETUP;
                  end
               end
               S_CHECK_MINUS: begin
                  if (reject_minus) begin
                     state_reg <= S_GEN_MINUS;
                  end else begin
                     x_minus         <= cand_x_reg;
                     y_minus         <= cand_y_reg;
                     minus_valid_reg <= 1'b1;
                     state_reg       <= S_DRAW_SETUP;
                  end
               end
               S_DRAW_SETUP: begin
                  both_reg  <= 1'b0;
                  state_reg <= S_DRAW;
               end
               S_DRAW: begin
                  if (draw_done) state_reg <= S_ACTIVE;
               end
               S_ACTIVE: begin
                  if (plus_hit) begin
                     plus_taken     <= 1'b1;
                     plus_valid_reg <= 1'b0;
                     cnt_reg        <= CNT_LOAD;
                     state_reg      <= S_RESPAWN_PLUS;
                  end else if (minus_hit) begin
                     minus_taken     <= 1'b1;
                     minus_valid_reg <= 1'b0;
                     cnt_reg         <= CNT_LOAD;
                     state_reg       <= S_RESPAWN_MINUS;
                  end
               end
               S_RESPAWN_PLUS, S_RESPAWN_MINUS: begin
                  if (cnt_reg == '0)
                     state_reg <= (state_reg == S_RESPAWN_PLUS) ? S_GEN_PLUS : S_GEN_MINUS;
                  else
                     cnt_reg <= cnt_reg - CNT_ONE;
               end
               default: state_reg <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_special_item_placer.sv
// Scoreboard bench for special_item_placer: each placement is predicted from a transaction-level
// model of the candidate search and checked when draw_special rises.
module tb_special_item_placer;

   logic       clk = 1'b0;
   logic       resetn, start, draw_done;
   logic       maze_wall = 1'b0;
   logic [4:0] player_x, player_y;
   logic [9:0] maze_addr;
   logic [4:0] x_plus, y_plus, x_minus, y_minus;
   logic       draw_special, plus_taken, minus_taken, busy;

   special_item_placer #(.RESPAWN_CYCLES(10)) dut (
      .clk(clk), .resetn(resetn), .start(start),
      .player_x(player_x), .player_y(player_y),
      .maze_addr(maze_addr), .maze_wall(maze_wall),
      .x_plus(x_plus), .y_plus(y_plus), .x_minus(x_minus), .y_minus(y_minus),
      .draw_special(draw_special), .draw_done(draw_done),
      .plus_taken(plus_taken), .minus_taken(minus_taken), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {int px; int py; int mx; int my; int lat;} exp_t;

   logic        wall [0:575];
   logic [15:0] ml;
   int          m_addr = 0;
   int          exp_trace[$];
   exp_t        sb[$];
   exp_t        cur, first_a;
   int          read_minus_k;
   int          vectors = 0;
   int          miscompares = 0;

   function automatic logic [15:0] adv(input logic [15:0] l);
      return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
   endfunction

   // wall memory with one-cycle registered read
   always_ff @(posedge clk) maze_wall <= (maze_addr < 10'd576) ? wall[maze_addr] : 1'b1;

   always_ff @(posedge clk) ml <= resetn ? adv(ml) : 16'hACE1;

   task automatic check_val(input string tag, input int got, input int exp);
      vectors++;
      if (got != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic place_one(inout logic [15:0] l, inout int cyc, input int gen_k,
                            input bit ov, input int ox, input int oy,
                            output int rx, output int ry, output int first_read);
      int cx, cy;
      first_read = -1; rx = 0; ry = 0;
      while (cyc < 50000) begin
         cx = int'(l[4:0]);
         cy = int'(l[9:5]);
         if (cx >= 24 || cy >= 24) begin
            l = adv(l); cyc++;
            exp_trace.push_back(m_addr);
            continue;
         end
         if (first_read < 0) first_read = gen_k + cyc + 1;
         m_addr = cy * 24 + cx;
         repeat (3) begin
            exp_trace.push_back(m_addr);
            l = adv(l);
         end
         cyc += 3;
         if (!wall[m_addr] && !(cx == int'(player_x) && cy == int'(player_y)) &&
             !(ov && cx == ox && cy == oy)) begin
            rx = cx; ry = cy;
            return;
         end
      end
   endtask

   // both=1: full two-item placement; both=0: plus respawn with minus kept at (kx,ky)
   task automatic predict(input bit both, input int gen_k, input int kx, input int ky);
      logic [15:0] l;
      int cyc, fr;
      exp_t e;
      l = ml;
      repeat (gen_k) l = adv(l);
      cyc = 0;
      exp_trace.delete();
      if (both) begin
         place_one(l, cyc, gen_k, 1'b0, 0, 0, e.px, e.py, fr);
         place_one(l, cyc, gen_k, 1'b1, e.px, e.py, e.mx, e.my, read_minus_k);
      end else begin
         place_one(l, cyc, gen_k, 1'b1, kx, ky, e.px, e.py, fr);
         e.mx = kx; e.my = ky;
      end
      e.lat = gen_k + cyc + 1;
      sb.push_back(e);
   endtask

   task automatic await_draw(input string tag, input int gen_k);
      exp_t e;
      int k, bad_addr, idle, pulses, got_lat, idx;
      e = sb.pop_front();
      k = 0; bad_addr = 0; idle = 0; pulses = 0; got_lat = -1;
      while (k < e.lat + 20) begin
         step(); k++;
         idx = k - gen_k - 1;
         if (idx >= 0 && idx < exp_trace.size())
            if (int'(maze_addr) != exp_trace[idx]) bad_addr++;
         if (!busy) idle++;
         if (plus_taken || minus_taken) pulses++;
         if (draw_special) begin
            got_lat = k;
            break;
         end
      end
      check_val({tag, "_latency"}, got_lat, e.lat);
      check_val({tag, "_addr_trace_errs"}, bad_addr, 0);
      check_val({tag, "_busy_gaps"}, idle, 0);
      check_val({tag, "_stray_pulses"}, pulses, 0);
      check_val({tag, "_x_plus"}, int'(x_plus), e.px);
      check_val({tag, "_y_plus"}, int'(y_plus), e.py);
      check_val({tag, "_x_minus"}, int'(x_minus), e.mx);
      check_val({tag, "_y_minus"}, int'(y_minus), e.my);
      check_val({tag, "_distinct"}, int'(x_plus != x_minus || y_plus != y_minus), 1);
      check_val({tag, "_plus_off_player"}, int'(x_plus == player_x && y_plus == player_y), 0);
      check_val({tag, "_in_range"}, int'(x_plus < 24 && y_plus < 24 && x_minus < 24 && y_minus < 24), 1);
      $display("%s: plus=(%0d,%0d) minus=(%0d,%0d) draw after %0d cycles",
               tag, x_plus, y_plus, x_minus, y_minus, got_lat);
      cur = e;
   endtask

   task automatic finish_draw(input string tag, input int delay);
      int bad = 0;
      for (int i = 0; i < delay; i++) begin
         step();
         if (!draw_special || int'(x_plus) != cur.px || int'(y_plus) != cur.py ||
             int'(x_minus) != cur.mx || int'(y_minus) != cur.my) bad++;
      end
      check_val({tag, "_hold_errs"}, bad, 0);
      draw_done = 1'b1;
      step();
      draw_done = 1'b0;
      check_val({tag, "_draw_low"}, int'(draw_special), 0);
      check_val({tag, "_active"}, int'(busy), 0);
   endtask

   task automatic start_pulse();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic release_and_start();
      resetn = 1'b1;
      repeat (5) step();
      start_pulse();
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_coords"}, int'({x_plus, y_plus, x_minus, y_minus}), 0);
      check_val({tag, "_maze_addr"}, int'(maze_addr), 0);
      check_val({tag, "_flags"}, int'({draw_special, plus_taken, minus_taken, busy}), 0);
   endtask

   initial begin
      for (int i = 0; i < 576; i++) wall[i] = 1'b0;
      resetn = 1'b0; start = 1'b0; draw_done = 1'b0;
      player_x = 5'd0; player_y = 5'd0;
      repeat (3) step();
      check_all_zero("reset");

      // empty maze, player at origin
      release_and_start();
      check_val("start_busy", int'(busy), 1);
      predict(1'b1, 0, 0, 0);
      await_draw("open_maze", 0);
      first_a = cur;
      finish_draw("hold200", 200);

      // plus pickup and respawn
      player_x = 5'(cur.px); player_y = 5'(cur.py);
      step();
      check_val("plus_pulse", int'({plus_taken, minus_taken}), 2);
      predict(1'b0, 10, cur.mx, cur.my);
      await_draw("respawn_plus", 10);
      finish_draw("respawn_done", 3);

      // start during RESPAWN_MINUS
      player_x = 5'(cur.mx); player_y = 5'(cur.my);
      step();
      check_val("minus_pulse", int'({plus_taken, minus_taken}), 1);
      repeat (3) step();
      player_x = 5'd0; player_y = 5'd0;
      start_pulse();
      check_val("restart_resp_busy", int'(busy), 1);
      predict(1'b1, 0, 0, 0);
      await_draw("restart_resp", 0);

      // start during DRAW, with draw_done in the same cycle
      start = 1'b1; draw_done = 1'b1;
      step();
      start = 1'b0; draw_done = 1'b0;
      check_val("restart_draw_low", int'(draw_special), 0);
      check_val("restart_draw_busy", int'(busy), 1);
      predict(1'b1, 0, 0, 0);
      await_draw("restart_draw", 0);
      finish_draw("restart_done", 2);

      // only two free cells
      for (int i = 0; i < 576; i++) wall[i] = 1'b1;
      wall[4 * 24 + 3] = 1'b0;
      wall[9 * 24 + 7] = 1'b0;
      start_pulse();
      predict(1'b1, 0, 0, 0);
      await_draw("two_free", 0);
      check_val("two_free_cells",
                int'((x_plus == 3 && y_plus == 4 && x_minus == 7 && y_minus == 9) ||
                     (x_plus == 7 && y_plus == 9 && x_minus == 3 && y_minus == 4)), 1);
      finish_draw("two_free_done", 1);

      // reset pulse during READ_MINUS, then reseeded replay
      for (int i = 0; i < 576; i++) wall[i] = 1'b0;
      start_pulse();
      predict(1'b1, 0, 0, 0);
      void'(sb.pop_back());
      for (int k = 0; k < read_minus_k; k++) step();
      resetn = 1'b0;
      step();
      m_addr = 0;
      check_all_zero("mid_reset");
      release_and_start();
      predict(1'b1, 0, 0, 0);
      await_draw("reseeded", 0);
      check_val("reseed_x_plus", int'(x_plus), first_a.px);
      check_val("reseed_x_minus", int'(x_minus), first_a.mx);
      finish_draw("reseeded_done", 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
